// File: rtl/pc_fetch_if.sv
// Fetch-stage bus bundle: the next-PC mux link, the instruction-memory
// request/ack port and the valid/ready handshake towards decode.
// The master modport is the fetch stage; slave is its environment.
interface pc_fetch_if;
  logic        redirect;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        pc_misalign;

  modport master (
    input  redirect, next_pc, imem_ack, imem_rdata, if_ready,
    output pc_plus4, imem_req, imem_addr, if_valid, if_pc, if_instr, pc_misalign
  );

  modport slave (
    output redirect, next_pc, imem_ack, imem_rdata, if_ready,
    input  pc_plus4, imem_req, imem_addr, if_valid, if_pc, if_instr, pc_misalign
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch program-counter stage. Holds the fetch PC, issues one
// outstanding request at a time to instruction memory and hands the fetched
// word to decode through a valid/ready handshake.
// Optional feature macro: PC_ALIGN_CHECK_EN -- forces redirect targets to
// word alignment and pulses pc_misalign when a target had bits [1:0] set.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  pc_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        if_valid_q;
  logic        imem_req_q;
  logic        pc_misalign_q;

  // Redirect target as it will be loaded, and whether it had to be fixed up.
  logic [31:0] target_pc_d;
  logic        misalign_d;

`ifdef PC_ALIGN_CHECK_EN
  assign target_pc_d = {bus.next_pc[31:2], 2'b00};
  // Every redirect sampled outside IDLE is accepted (REQ, KILL and HOLD all act on it).
  assign misalign_d  = bus.redirect && (state_q != IDLE) && (bus.next_pc[1:0] != 2'b00);
`else
  assign target_pc_d = bus.next_pc;
  assign misalign_d  = 1'b0;
`endif

  // Outputs are register copies; imem_addr is the fetch PC itself, which is
  // never touched while a request is outstanding.
  assign bus.imem_addr   = pc_q;
  assign bus.pc_plus4    = if_pc_q + PC_STEP;
  assign bus.imem_req    = imem_req_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.pc_misalign = pc_misalign_q;

  // Fetch FSM with all state and registered outputs updated together.
  // NOTE: sequential state uses non-blocking (<=) so every register sees the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= RESET_PC;
      if_pc_q       <= RESET_PC;
      if_instr_q    <= 32'h0;
      if_valid_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      pc_misalign_q <= 1'b0;
    end else begin
      pc_misalign_q <= misalign_d;
      unique case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end

        REQ: begin
          if (bus.imem_ack) begin
            if (bus.redirect) begin
              // Word returned for a now-stale path: drop it, refetch at target.
              pc_q <= target_pc_d;
            end else begin
              if_instr_q <= bus.imem_rdata;
              if_pc_q    <= pc_q;
              pc_q       <= pc_q + PC_STEP;
              if_valid_q <= 1'b1;
              imem_req_q <= 1'b0;
              state_q    <= HOLD;
            end
          end else if (bus.redirect) begin
            // Request still in flight: remember the target, wait out the ack.
            pend_pc_q <= target_pc_d;
            state_q   <= KILL;
          end
        end

        KILL: begin
          if (bus.imem_ack) begin
            pc_q    <= bus.redirect ? target_pc_d : pend_pc_q;
            state_q <= REQ;
          end else if (bus.redirect) begin
            pend_pc_q <= target_pc_d;
          end
        end

        HOLD: begin
          if (bus.redirect) begin
            // Redirect wins over a same-cycle handshake: instruction is squashed.
            pc_q       <= target_pc_d;
            if_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
            state_q    <= REQ;
          end else if (bus.if_ready) begin
            if_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
            state_q    <= REQ;
          end
        end

        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset values, sequential fetch, decode
// back-pressure, redirects during/with/after a request, address wrap,
// reset mid-request and the optional alignment feature (PC_ALIGN_CHECK_EN).
module tb_pc_fetch;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  pc_fetch_if bus ();

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.redirect   = 1'b0;
    bus.next_pc    = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.if_ready   = 1'b0;

    // Reset held three cycles.
    repeat (3) step();
    check("rst_req",      32'(bus.imem_req), 32'h0);
    check("rst_addr",     bus.imem_addr, 32'h0);
    check("rst_if_pc",    bus.if_pc, 32'h0);
    check("rst_instr",    bus.if_instr, 32'h0);
    check("rst_valid",    32'(bus.if_valid), 32'h0);
    check("rst_misalign", 32'(bus.pc_misalign), 32'h0);
    check("rst_plus4",    bus.pc_plus4, 32'h4);

    // Release: this cycle is IDLE, next is the first request.
    rst = 1'b0;
    #1;
    check("idle_req", 32'(bus.imem_req), 32'h0);
    step();
    check("req0_req",  32'(bus.imem_req), 32'h1);
    check("req0_addr", bus.imem_addr, 32'h0);

    // Zero-wait ack at address 0, decode ready.
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00A0_0093; bus.if_ready = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("cap0_valid", 32'(bus.if_valid), 32'h1);
    check("cap0_instr", bus.if_instr, 32'h00A0_0093);
    check("cap0_pc",    bus.if_pc, 32'h0);
    check("cap0_plus4", bus.pc_plus4, 32'h4);
    check("cap0_req",   32'(bus.imem_req), 32'h0);
    step();
    check("req4_addr",  bus.imem_addr, 32'h4);
    check("req4_req",   32'(bus.imem_req), 32'h1);
    check("req4_valid", 32'(bus.if_valid), 32'h0);

    // Fetch at 4 with decode stalled; stray acks in HOLD must be ignored.
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0010_0113; bus.if_ready = 1'b0;
    step();
    bus.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(bus.if_valid), 32'h1);
      check("stall_instr", bus.if_instr, 32'h0010_0113);
      check("stall_pc",    bus.if_pc, 32'h4);
      check("stall_req",   32'(bus.imem_req), 32'h0);
    end
    bus.imem_ack = 1'b0; bus.if_ready = 1'b1;
    step();
    check("req8_addr",  bus.imem_addr, 32'h8);
    check("req8_req",   32'(bus.imem_req), 32'h1);
    check("req8_valid", 32'(bus.if_valid), 32'h0);

    // Redirect to 0x100 while the request at 8 is outstanding; ack 3rd cycle.
    bus.redirect = 1'b1; bus.next_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    check("kill_addr1",  bus.imem_addr, 32'h8);
    check("kill_req1",   32'(bus.imem_req), 32'h1);
    check("kill_valid1", 32'(bus.if_valid), 32'h0);
    step();
    check("kill_addr2",  bus.imem_addr, 32'h8);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("kill_done_addr",  bus.imem_addr, 32'h100);
    check("kill_done_valid", 32'(bus.if_valid), 32'h0);
    check("kill_done_req",   32'(bus.imem_req), 32'h1);

    // Redirect in the same cycle as the ack: word dropped.
    bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.next_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    check("ackredir_addr",  bus.imem_addr, 32'h40);
    check("ackredir_valid", 32'(bus.if_valid), 32'h0);
    check("ackredir_req",   32'(bus.imem_req), 32'h1);
    bus.imem_rdata = 32'h0020_8193;
    step();
    bus.imem_ack = 1'b0;
    check("cap40_valid", 32'(bus.if_valid), 32'h1);
    check("cap40_pc",    bus.if_pc, 32'h40);
    check("cap40_instr", bus.if_instr, 32'h0020_8193);
    check("cap40_plus4", bus.pc_plus4, 32'h44);

    // Redirect in HOLD with decode ready: no transfer, straight to target.
    bus.redirect = 1'b1; bus.next_pc = 32'h200; bus.if_ready = 1'b1;
    step();
    bus.redirect = 1'b0;
    check("holdredir_valid", 32'(bus.if_valid), 32'h0);
    check("holdredir_addr",  bus.imem_addr, 32'h200);
    check("holdredir_req",   32'(bus.imem_req), 32'h1);
    check("holdredir_pc",    bus.if_pc, 32'h40);

    // Misaligned redirect taken with an ack.
    bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.next_pc = 32'h102;
    step();
    bus.imem_ack = 1'b0; bus.redirect = 1'b0;
    check("mis_addr",  bus.imem_addr, ALIGN ? 32'h100 : 32'h102);
    check("mis_pulse", 32'(bus.pc_misalign), 32'(ALIGN));
    step();
    check("mis_pulse_end", 32'(bus.pc_misalign), 32'h0);

    // Misaligned redirect via the deferred (pend_pc) path.
    bus.redirect = 1'b1; bus.next_pc = 32'h303;
    step();
    bus.redirect = 1'b0;
    check("pmis_pulse", 32'(bus.pc_misalign), 32'(ALIGN));
    step();
    check("pmis_pulse_end", 32'(bus.pc_misalign), 32'h0);
    check("pmis_hold_addr", bus.imem_addr, ALIGN ? 32'h100 : 32'h102);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("pmis_addr", bus.imem_addr, ALIGN ? 32'h300 : 32'h303);

    // Address wrap at the top of the 32-bit space.
    bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.next_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0; bus.imem_rdata = 32'h0000_0013;
    check("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    bus.imem_ack = 1'b0;
    check("wrap_pc",    bus.if_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", bus.pc_plus4, 32'h0);
    step();
    check("wrap_addr", bus.imem_addr, 32'h0);

    // Reset in the middle of an outstanding request; late ack ignored.
    rst = 1'b1;
    step();
    check("mrst_req",   32'(bus.imem_req), 32'h0);
    check("mrst_addr",  bus.imem_addr, 32'h0);
    check("mrst_instr", bus.if_instr, 32'h0);
    rst = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    step();
    bus.imem_ack = 1'b0;
    check("mrst_after_valid", 32'(bus.if_valid), 32'h0);
    check("mrst_after_req",   32'(bus.imem_req), 32'h1);
    check("mrst_after_addr",  bus.imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
